// File: rtl/apple1_bus_ctrl.sv
// Apple-1 bus controller: registered bus-cycle FSM between the 6502 core and RAM/ROM/I/O.
// Decodes NUM_IO two-byte I/O windows, write-protects ROM, and inserts RAM wait states.
module apple1_bus_ctrl #(
    parameter int unsigned NUM_IO   = 4,
    parameter logic [15:0] IO_BASE  = 16'hD010,
    parameter int unsigned RAM_WAIT = 1,
    parameter logic [15:0] ROM_BASE = 16'hFF00
) (
    input  logic                  clk14_i,
    input  logic                  rst_i,
    input  logic                  cpu_clken_i,
    input  logic [15:0]           cpu_addr_i,
    input  logic                  cpu_we_i,
    input  logic [7:0]            cpu_dout_i,
    output logic [7:0]            cpu_din_o,
    output logic                  cpu_ready_o,
    output logic [15:0]           ram_addr_o,
    output logic                  ram_rd_o,
    output logic                  ram_wr_o,
    input  logic [7:0]            ram_dout_i,
    output logic [7:0]            wdata_o,
    output logic [NUM_IO-1:0]     io_cs_o,
    output logic                  io_a0_o,
    output logic                  io_we_o,
    output logic                  io_rd_o,
    input  logic [8*NUM_IO-1:0]   io_dout_i,
    output logic                  rom_wr_err_o
);

    typedef enum logic [1:0] {StStart, StAccess, StDone} state_e;

    state_e              state_q;
    logic [3:0]          wait_q;
    logic [7:0]          cpu_din_q;
    logic                cpu_ready_q;
    logic [15:0]         ram_addr_q;
    logic                ram_rd_q;
    logic                ram_wr_q;
    logic [7:0]          wdata_q;
    logic [NUM_IO-1:0]   io_cs_q;
    logic                io_a0_q;
    logic                io_we_q;
    logic                io_rd_q;
    logic                rom_wr_err_q;

    logic [NUM_IO-1:0]   io_hit;
    logic [7:0]          io_rdata;

    // Window decode on the live CPU address; bit 0 selects the register inside a window.
    always_comb begin
        io_hit   = '0;
        io_rdata = 8'hFF;
        for (int unsigned k = 0; k < NUM_IO; k++) begin
            if (cpu_addr_i[15:1] == IO_BASE[15:1] + 15'(k)) begin
                io_hit[k] = 1'b1;
                io_rdata  = io_dout_i[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk14_i) begin
        if (rst_i) begin
            state_q      <= StStart;
            wait_q       <= 4'd0;
            cpu_din_q    <= 8'hFF;
            cpu_ready_q  <= 1'b0;
            ram_addr_q   <= 16'h0000;
            ram_rd_q     <= 1'b0;
            ram_wr_q     <= 1'b0;
            wdata_q      <= 8'h00;
            io_cs_q      <= '0;
            io_a0_q      <= 1'b0;
            io_we_q      <= 1'b0;
            io_rd_q      <= 1'b0;
            rom_wr_err_q <= 1'b0;
        end else begin
            // Write and I/O strobes are single-cycle pulses.
            ram_wr_q <= 1'b0;
            io_we_q  <= 1'b0;
            io_rd_q  <= 1'b0;
            io_cs_q  <= '0;
            unique case (state_q)
                StStart: begin
                    ram_addr_q <= cpu_addr_i;
                    wdata_q    <= cpu_dout_i;
                    io_a0_q    <= cpu_addr_i[0];
                    if (|io_hit) begin
                        io_cs_q     <= io_hit;
                        io_we_q     <= cpu_we_i;
                        io_rd_q     <= !cpu_we_i;
                        if (!cpu_we_i) begin
                            cpu_din_q <= io_rdata;
                        end
                        cpu_ready_q <= 1'b1;
                        state_q     <= StDone;
                    end else if (!cpu_we_i) begin
                        ram_rd_q <= 1'b1;
                        wait_q   <= 4'(RAM_WAIT);
                        state_q  <= StAccess;
                    end else begin
                        if (cpu_addr_i < ROM_BASE) begin
                            ram_wr_q <= 1'b1;
                        end else begin
                            rom_wr_err_q <= 1'b1;
                        end
                        cpu_ready_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StAccess: begin
                    if (wait_q == 4'd0) begin
                        ram_rd_q    <= 1'b0;
                        cpu_din_q   <= ram_dout_i;
                        cpu_ready_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                StDone: begin
                    if (cpu_clken_i) begin
                        cpu_ready_q <= 1'b0;
                        state_q     <= StStart;
                    end
                end
                default: state_q <= StStart;
            endcase
        end
    end

    assign cpu_din_o    = cpu_din_q;
    assign cpu_ready_o  = cpu_ready_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_rd_o     = ram_rd_q;
    assign ram_wr_o     = ram_wr_q;
    assign wdata_o      = wdata_q;
    assign io_cs_o      = io_cs_q;
    assign io_a0_o      = io_a0_q;
    assign io_we_o      = io_we_q;
    assign io_rd_o      = io_rd_q;
    assign rom_wr_err_o = rom_wr_err_q;

endmodule

// File: doc/apple1_bus_ctrl.md
Name: apple1_bus_ctrl

Overview:
Parametrised bus controller between the 6502 core and the RAM/ROM and peripheral interfaces of the Apple-1 system. It replaces flat combinational address decoding and the CPU data-in mux with a registered bus-cycle state machine. The controller decodes NUM_IO two-byte I/O windows and enforces write protection on the top ROM region. It inserts programmable RAM wait states and stalls the CPU via cpu_ready when an access outlasts one CPU clock.

Parameters:
NUM_IO, 4, number of 2-byte I/O windows (1..8); window k decodes IO_BASE+2k..IO_BASE+2k+1
IO_BASE, 16'hD010, base of window 0 (bit 0 ignored)
RAM_WAIT, 1, extra clk14 cycles a RAM access is held (0..15)
ROM_BASE, 16'hFF00, addresses >= ROM_BASE are write-protected

Ports:
clk14  input  1  14 MHz master clock
rst  input  1  synchronous reset, active high
cpu_clken  input  1  one-cycle CPU clock-enable strobe from the clock divider
cpu_addr  input  16  CPU address
cpu_we  input  1  CPU write enable
cpu_dout  input  8  CPU write data
cpu_din  output  8  registered read data to CPU
cpu_ready  output  1  high = current bus cycle complete; CPU may advance
ram_addr  output  16  latched RAM address
ram_rd  output  1  RAM read strobe
ram_wr  output  1  RAM write strobe, one cycle
ram_dout  input  8  RAM read data
wdata  output  8  latched write data (RAM and I/O)
io_cs  output  NUM_IO  one-hot window select
io_a0  output  1  latched address bit 0
io_we  output  1  I/O write strobe, one cycle
io_rd  output  1  I/O read strobe, one cycle
io_dout  input  8*NUM_IO  per-window read data; window k on bits [8k+7:8k]
rom_wr_err  output  1  sticky flag: a write to protected ROM was attempted

Behaviour:
- Synchronous, active-high reset. Polarity and synchronicity are fixed.
- Reset values: state=START, cpu_din=8'hFF, cpu_ready=0, ram_rd=ram_wr=io_we=io_rd=0, io_cs=0, rom_wr_err=0.
- ram_addr, wdata and io_a0 reset to 0.
- States: START, ACCESS, DONE.
- START (1 cycle):
  - Latch cpu_addr, cpu_we and cpu_dout.
  - Decode: io hit k when addr[15:1]==IO_BASE[15:1]+k for k<NUM_IO; all other addresses are RAM.
  - I/O: assert io_cs[k]; pulse io_we (write) or io_rd (read); go to DONE, sampling io_dout window k into cpu_din on that edge.
  - RAM read: assert ram_rd; load wait counter with RAM_WAIT; go to ACCESS.
  - RAM write, addr < ROM_BASE: pulse ram_wr for this cycle only; go to DONE.
  - RAM write, addr >= ROM_BASE: no strobe; set rom_wr_err; go to DONE.
- ACCESS:
  - ram_rd stays high and the counter decrements.
  - When the counter is 0, sample ram_dout into cpu_din and go to DONE.
  - ram_rd is therefore high for RAM_WAIT+1 cycles.
- DONE:
  - cpu_ready=1; io_cs and strobes are deasserted.
  - cpu_din holds until the next read completes; writes leave cpu_din unchanged.
- cpu_ready is 1 only in DONE.
- cpu_clken in DONE consumes the cycle: next state is START and cpu_ready drops on the following edge.
- cpu_clken in START or ACCESS is ignored. The CPU sees ready=0 and holds its address, so the access completes on a later strobe. No access is ever issued twice.
- cpu_clken and the ACCESS→DONE transition in the same cycle: go to DONE; that strobe is not consumed.
- With a 14-cycle clken period, RAM_WAIT<=11 never stalls the CPU.
- rom_wr_err clears only on rst.
- Reset mid-ACCESS: ram_rd drops on the next edge; no write strobe is generated; state=START.
- Overlapping windows cannot occur. Window decode has priority over RAM, so I/O addresses never produce RAM strobes.

Test Plan:
- RAM_WAIT=2, clken every 14 cycles; read 0x0300 with ram_dout=0x5A -> ram_rd high exactly 3 cycles; cpu_din=0x5A; cpu_ready=1 four cycles after START; no stall.
- RAM_WAIT=15, clken every 4 cycles; read 0x1000 -> first clken after START sees cpu_ready=0; single START; completes 17 cycles after START; next clken consumed.
- Write 0x41 to 0xD012 (NUM_IO=4) -> io_cs=4'b0010, io_a0=0, wdata=0x41, one-cycle io_we; no ram_wr. Read 0xD017 with window 3 data 0xC3 -> io_cs=4'b1000, io_a0=1, cpu_din=0xC3.
- Write 0x00 to 0xFF10 -> no ram_wr; rom_wr_err=1 and held through later accesses. Write to 0xFEFF -> ram_wr pulses once.
- Assert rst during ACCESS of a RAM read -> next cycle ram_rd=0, cpu_ready=0, cpu_din=0xFF, state START; after release the first access proceeds normally.
- Back-to-back: read 0x0000 then write 0x0001 on consecutive clken -> cpu_din keeps the read value after the write; exactly one ram_wr pulse.
